// File: rtl/seq_divider_64b_if.sv
// Start/done bundle between the control unit (master) and the iterative divider (slave).
// WIDTH must match the WIDTH of the divider this bundle is bound to.
interface seq_divider_64b_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_64b.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Optional SIGNED_DIV_EN: honours is_signed (magnitude divide plus sign fix-up on the DONE edge).
module seq_divider_64b #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  seq_divider_64b_if.slave bus,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: start is sampled only in IDLE or DONE; an accepted start drops done on
  // the same edge. busy is high for the whole RUN phase, and done (with div_by_zero,
  // quotient, remainder) holds until the next accepted start.

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             signed_mode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] sub;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             last_iter;

`ifdef SIGNED_DIV_EN
  assign signed_mode = bus.is_signed;
`else
  logic unused_is_signed;
  assign signed_mode      = 1'b0;
  assign unused_is_signed = bus.is_signed;
`endif

  assign a_neg = signed_mode & bus.dividend[WIDTH-1];
  assign b_neg = signed_mode & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  // One restoring step. The shifted partial remainder is WIDTH+1 bits; when its top bit
  // is set it certainly exceeds the divisor, and the WIDTH-bit difference is still exact.
  always_comb begin
    wide   = {rem_q, quo_q[WIDTH-1]};
    rem_sh = wide[WIDTH-1:0];
    sub    = rem_sh - dvsr_q;
    borrow = !wide[WIDTH] && (rem_sh < dvsr_q);
    rem_nx = borrow ? rem_sh : sub;
    quo_nx = {quo_q[WIDTH-2:0], ~borrow};
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          cnt_d = '0;
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            // Division by zero finishes on the accept edge itself.
            state_d     = S_DONE;
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            neg_quo_d   = 1'b0;
            neg_rem_d   = 1'b0;
          end else begin
            state_d     = S_RUN;
            rem_d       = '0;
            quo_d       = a_mag;
            dvsr_d      = b_mag;
            neg_quo_d   = a_neg ^ b_neg;
            neg_rem_d   = a_neg;
            quotient_d  = '0;
            remainder_d = '0;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // Sign fix-up folds into the final iteration's edge, costing no extra cycle.
          state_d     = S_DONE;
          quotient_d  = neg_quo_q ? -quo_nx : quo_nx;
          remainder_d = neg_rem_q ? -rem_nx : rem_nx;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign dbg_state       = state_q;

endmodule
